world_arbiter: RTL and testbench

Two-requester arbiter sharing the single port of the 64x64 maze world memory (6-bit row, 6-bit col, 1-bit cell). It sits between the world memory and its two masters: the maze solver (requester 0) and the result scanner/display walker (requester 1). Access is round-robin with a bounded burst length, so neither master starves. Read data returns one cycle after grant, matching the world's synchronous read.

---
 rtl/world_arbiter_if.sv | 49 ++++
 rtl/world_arbiter.sv | 126 ++++++++++++
 tb/tb_world_arbiter.sv | 309 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/world_arbiter_if.sv
// Bundle of the two requester ports and the world-memory port that the
// arbiter sits between. The master side is the environment (both
// requesters plus the world memory); the slave side is the arbiter.
interface world_arbiter_if;
    // requester 0 (maze solver)
    logic       req0;
    logic [5:0] row0;
    logic [5:0] col0;
    logic       we0;
    logic       wdata0;
    logic       gnt0;
    logic       rvalid0;

    // requester 1 (result scanner / display walker)
    logic       req1;
    logic [5:0] row1;
    logic [5:0] col1;
    logic       we1;
    logic       wdata1;
    logic       gnt1;
    logic       rvalid1;

    // shared read data back to both requesters
    logic       rdata;

    // world memory port
    logic [5:0] row;
    logic [5:0] col;
    logic       oe;
    logic       we;
    logic       wdata;
    logic       maze_in;

    modport master (
        output req0, row0, col0, we0, wdata0,
        output req1, row1, col1, we1, wdata1,
        output maze_in,
        input  gnt0, gnt1, rvalid0, rvalid1, rdata,
        input  row, col, oe, we, wdata
    );

    modport slave (
        input  req0, row0, col0, we0, wdata0,
        input  req1, row1, col1, we1, wdata1,
        input  maze_in,
        output gnt0, gnt1, rvalid0, rvalid1, rdata,
        output row, col, oe, we, wdata
    );
endinterface

// File: rtl/world_arbiter.sv
// Round-robin arbiter for the single port of the 64x64 maze world memory.
// Grants are combinational from the current state and requests, so an
// uncontended request is issued in the cycle it appears. Under contention
// the current owner keeps the port for at most BURST consecutive grants.
// Read data comes straight from the world one cycle after the grant; the
// matching rvalid is the grant delayed by one register.
module world_arbiter #(
    parameter int BURST = 4
) (
    input  logic            clk,
    input  logic            rst,
    world_arbiter_if.slave  bus
);

    localparam logic [3:0] BURST_C = 4'(BURST);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic [3:0] cnt;
    logic [3:0] cnt_nxt;
    logic       last;
    logic       last_nxt;
    logic       gnt0_c;
    logic       gnt1_c;
    logic       vld0_p1;
    logic       vld1_p1;

    // Grant count while staying with one owner; it parks at BURST when the
    // owner is alone so a late-arriving competitor is served at once.
    function automatic logic [3:0] sat_inc(input logic [3:0] c);
        return (c < BURST_C) ? c + 4'd1 : BURST_C;
    endfunction

    // State, burst count, tie-break memory and the one-cycle read-valid pipe.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            last    <= 1'b1;
            vld0_p1 <= 1'b0;
            vld1_p1 <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            last    <= last_nxt;
            vld0_p1 <= gnt0_c & ~bus.we0;
            vld1_p1 <= gnt1_c & ~bus.we1;
        end
    end

    // Grant decision and next state: a lone request always wins; a tie goes
    // to the current owner until its burst is used up, or from IDLE to the
    // requester that was not served last.
    always_comb begin
        gnt0_c    = 1'b0;
        gnt1_c    = 1'b0;
        state_nxt = IDLE;
        cnt_nxt   = 4'd0;
        last_nxt  = last;

        if (bus.req0 && bus.req1) begin
            case (state)
                OWN0: begin
                    if (cnt < BURST_C) gnt0_c = 1'b1;
                    else               gnt1_c = 1'b1;
                end
                OWN1: begin
                    if (cnt < BURST_C) gnt1_c = 1'b1;
                    else               gnt0_c = 1'b1;
                end
                default: begin
                    if (last) gnt0_c = 1'b1;
                    else      gnt1_c = 1'b1;
                end
            endcase
        end else begin
            gnt0_c = bus.req0;
            gnt1_c = bus.req1;
        end

        if (gnt0_c) begin
            state_nxt = OWN0;
            cnt_nxt   = (state == OWN0) ? sat_inc(cnt) : 4'd1;
            last_nxt  = 1'b0;
        end else if (gnt1_c) begin
            state_nxt = OWN1;
            cnt_nxt   = (state == OWN1) ? sat_inc(cnt) : 4'd1;
            last_nxt  = 1'b1;
        end
    end

    // Memory port: steer the granted requester's command, drive zeros when idle.
    always_comb begin
        bus.row   = 6'd0;
        bus.col   = 6'd0;
        bus.wdata = 1'b0;
        bus.we    = 1'b0;
        bus.oe    = 1'b0;
        if (gnt0_c) begin
            bus.row   = bus.row0;
            bus.col   = bus.col0;
            bus.wdata = bus.wdata0;
            bus.we    = bus.we0;
            bus.oe    = ~bus.we0;
        end else if (gnt1_c) begin
            bus.row   = bus.row1;
            bus.col   = bus.col1;
            bus.wdata = bus.wdata1;
            bus.we    = bus.we1;
            bus.oe    = ~bus.we1;
        end
    end

    assign bus.gnt0    = gnt0_c;
    assign bus.gnt1    = gnt1_c;
    assign bus.rvalid0 = vld0_p1;
    assign bus.rvalid1 = vld1_p1;
    assign bus.rdata   = bus.maze_in;

endmodule

// File: tb/tb_world_arbiter.sv
// Bench for world_arbiter: a world-memory model behind the arbiter, a
// reference arbitration model that queues expected port commands and read
// returns, and a monitor that pops and compares them every cycle.
module tb_world_arbiter;

    localparam int BURST = 4;

    logic clk;
    logic rst;
    world_arbiter_if bus ();

    world_arbiter #(.BURST(BURST)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- world memory (environment) ----------------
    logic world_mem [0:4095];
    logic maze_q;
    bit   mem_clear = 1'b1;

    // Synchronous-read world: data for an oe cycle appears the next cycle.
    always @(posedge clk) begin
        if (mem_clear) begin
            for (int i = 0; i < 4096; i++) world_mem[i] <= 1'b0;
            maze_q <= 1'b0;
        end else begin
            if (bus.oe) maze_q <= world_mem[{bus.row, bus.col}];
            if (bus.we) world_mem[{bus.row, bus.col}] <= bus.wdata;
        end
    end
    assign bus.maze_in = maze_q;

    // ---------------- scoreboard ----------------
    typedef struct packed {
        logic       g0;
        logic       g1;
        logic [5:0] row;
        logic [5:0] col;
        logic       oe;
        logic       we;
        logic       wdata;
    } drv_t;

    typedef struct {
        int   cyc;
        drv_t d;
    } gexp_t;

    typedef struct {
        int who;
        bit data;
        int due;
    } rexp_t;

    gexp_t gq[$];
    rexp_t rq[$];
    int nchk = 0;
    int nerr = 0;
    int cyc  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        nchk++;
        if (act !== req) begin
            nerr++;
            $display("FAIL %s at cycle %0d: got %0h, required %0h", name, cyc, act, req);
        end
    endtask

    // ---------------- reference model ----------------
    // Tracks who was granted in the previous cycle, how many consecutive
    // grants that owner has had, and who won most recently.
    bit shadow [0:4095];
    bit known = 1'b0;
    int prev_owner = -1;
    int streak = 0;
    int last_win = 1;
    int last_g = -1;

    function automatic int pick(input bit q0, input bit q1);
        if (!q0 && !q1) return -1;
        if (q0 != q1)   return q0 ? 0 : 1;
        if (prev_owner < 0) return 1 - last_win;
        if (streak < BURST) return prev_owner;
        return 1 - prev_owner;
    endfunction

    task automatic model_reset();
        prev_owner = -1;
        streak     = 0;
        last_win   = 1;
    endtask

    task automatic apply(input bit r,
                         input bit q0, input int r0, input int c0, input bit w0, input bit d0,
                         input bit q1, input int r1, input int c1, input bit w1, input bit d1);
        int    g;
        drv_t  d;
        gexp_t ge;
        rexp_t re;
        int    addr;
        bit    wr;
        bit    dat;
        @(negedge clk);
        rst        = r;
        bus.req0   = q0; bus.row0 = 6'(r0); bus.col0 = 6'(c0); bus.we0 = w0; bus.wdata0 = d0;
        bus.req1   = q1; bus.row1 = 6'(r1); bus.col1 = 6'(c1); bus.we1 = w1; bus.wdata1 = d1;
        cyc++;
        if (!known) begin
            if (r) begin
                known = 1'b1;
                model_reset();
            end
            last_g = -1;
            return;
        end
        g = pick(q0, q1);
        d = '0;
        if (g == 0) begin
            d.g0 = 1'b1; d.row = 6'(r0); d.col = 6'(c0); d.we = w0; d.oe = !w0; d.wdata = d0;
        end else if (g == 1) begin
            d.g1 = 1'b1; d.row = 6'(r1); d.col = 6'(c1); d.we = w1; d.oe = !w1; d.wdata = d1;
        end
        ge.cyc = cyc;
        ge.d   = d;
        gq.push_back(ge);
        if (g >= 0) begin
            addr = (g == 0) ? r0 * 64 + c0 : r1 * 64 + c1;
            wr   = (g == 0) ? w0 : w1;
            dat  = (g == 0) ? d0 : d1;
            if (!wr && !r) begin
                re.who  = g;
                re.data = shadow[addr];
                re.due  = cyc + 1;
                rq.push_back(re);
            end
            if (wr) shadow[addr] = dat;
        end
        if (r) begin
            model_reset();
        end else if (g < 0) begin
            prev_owner = -1;
            streak     = 0;
        end else begin
            if (g == prev_owner) streak = (streak < BURST) ? streak + 1 : BURST;
            else                 streak = 1;
            prev_owner = g;
            last_win   = g;
        end
        last_g = g;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) apply(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // ---------------- monitor ----------------
    initial begin
        gexp_t ge;
        rexp_t re;
        drv_t  act;
        forever begin
            @(negedge clk);
            #3;
            if (gq.size() != 0) begin
                ge  = gq.pop_front();
                act = {bus.gnt0, bus.gnt1, bus.row, bus.col, bus.oe, bus.we, bus.wdata};
                chk("port drive", 32'(act), 32'(ge.d));
            end
            if (bus.rvalid0 || bus.rvalid1) begin
                if (rq.size() == 0) begin
                    chk("spurious rvalid", {30'd0, bus.rvalid1, bus.rvalid0}, 32'd0);
                end else begin
                    re = rq.pop_front();
                    chk("rvalid owner", {30'd0, bus.rvalid1, bus.rvalid0},
                        (re.who == 1) ? 32'd2 : 32'd1);
                    chk("rdata", {31'd0, bus.rdata}, {31'd0, re.data});
                    chk("rvalid cycle", cyc, re.due);
                end
            end else if (rq.size() != 0 && rq[0].due <= cyc) begin
                re = rq.pop_front();
                chk("missing rvalid", {30'd0, bus.rvalid1, bus.rvalid0},
                    (re.who == 1) ? 32'd2 : 32'd1);
            end
        end
    end

    // Hard stop in case the stimulus never completes.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, errors=%0d", nerr);
        $fatal(1, "watchdog expired");
    end

    // ---------------- stimulus ----------------
    function automatic int rand_coord();
        return ($urandom_range(0, 9) == 0) ? 63 : int'($urandom_range(0, 3));
    endfunction

    initial begin
        bit   exp_rd [0:2];
        bit   seq [0:15];
        bit   p0, p1, pw0, pw1, pd0, pd1, rr;
        int   pr0, pc0, pr1, pc1;

        rst = 1'b1;
        bus.req0 = 0; bus.row0 = 0; bus.col0 = 0; bus.we0 = 0; bus.wdata0 = 0;
        bus.req1 = 0; bus.row1 = 0; bus.col1 = 0; bus.we1 = 0; bus.wdata1 = 0;
        @(posedge clk);
        #1 mem_clear = 1'b0;

        // Reset two cycles with both requesting, then the tie goes to 0.
        apply(1, 1, 1, 1, 0, 0, 1, 2, 2, 0, 0);
        apply(1, 1, 1, 1, 0, 0, 1, 2, 2, 0, 0);
        apply(0, 1, 1, 1, 0, 0, 1, 2, 2, 0, 0);
        #1;
        chk("rvalid after reset", {30'd0, bus.rvalid1, bus.rvalid0}, 32'd0);
        chk("first grant after reset", {30'd0, bus.gnt1, bus.gnt0}, 32'd1);
        idle(1);

        // Seed cells (3,5)=0, (3,6)=1, (3,7)=0 through requester 1.
        apply(0, 0, 0, 0, 0, 0, 1, 3, 5, 1, 0);
        apply(0, 0, 0, 0, 0, 0, 1, 3, 6, 1, 1);
        apply(0, 0, 0, 0, 0, 0, 1, 3, 7, 1, 0);
        idle(1);

        // Single reader, back-to-back reads.
        exp_rd[0] = 1'b0; exp_rd[1] = 1'b1; exp_rd[2] = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i < 3) apply(0, 1, 3, 5 + i, 0, 0, 0, 0, 0, 0, 0);
            else       idle(1);
            #1;
            if (i < 3)
                chk("single read gnt0/oe/we", {29'd0, bus.gnt0, bus.oe, bus.we}, 32'd6);
            if (i > 0)
                chk("single read rvalid0/rdata", {30'd0, bus.rvalid0, bus.rdata},
                    {30'd0, 1'b1, exp_rd[i-1]});
        end

        // Contention with BURST=4: last winner is 1 so the tie starts at 0.
        apply(0, 0, 0, 0, 0, 0, 1, 1, 1, 0, 0);
        idle(1);
        for (int i = 0; i < 16; i++) seq[i] = ((i / 4) % 2) == 1;
        for (int i = 0; i < 16; i++) begin
            apply(0, 1, 0, i, 0, 0, 1, 1, i, 0, 0);
            #1;
            chk("contention grant", {30'd0, bus.gnt1, bus.gnt0}, seq[i] ? 32'd2 : 32'd1);
        end
        idle(1);

        // Idle tie-break: serve 1, idle, then a simultaneous tie goes to 0.
        apply(0, 0, 0, 0, 0, 0, 1, 2, 3, 0, 0);
        idle(3);
        apply(0, 1, 2, 2, 0, 0, 1, 2, 3, 0, 0);
        #1;
        chk("idle tie-break", {30'd0, bus.gnt1, bus.gnt0}, 32'd1);
        idle(1);

        // Write (63,63)=1 then read it back immediately.
        apply(0, 0, 0, 0, 0, 0, 1, 63, 63, 1, 1);
        #1;
        chk("write cycle gnt1/oe/we", {29'd0, bus.gnt1, bus.oe, bus.we}, 32'd5);
        apply(0, 0, 0, 0, 0, 0, 1, 63, 63, 0, 0);
        idle(1);
        #1;
        chk("read after write", {30'd0, bus.rvalid1, bus.rdata}, 32'd3);

        // Reset in the middle of a requester-0 burst.
        apply(0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        apply(0, 1, 0, 2, 0, 0, 0, 0, 0, 0, 0);
        apply(1, 1, 0, 3, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            apply(0, 1, 0, 3, 0, 0, 1, 0, 4, 0, 0);
            #1;
            if (i == 0) chk("rvalid0 after mid-burst reset", {31'd0, bus.rvalid0}, 32'd0);
            chk("post-reset burst", {30'd0, bus.gnt1, bus.gnt0}, (i < 4) ? 32'd1 : 32'd2);
        end
        idle(1);

        // Random traffic; requesters hold their command until granted.
        p0 = 0; p1 = 0; pw0 = 0; pw1 = 0; pd0 = 0; pd1 = 0;
        pr0 = 0; pc0 = 0; pr1 = 0; pc1 = 0;
        for (int i = 0; i < 3000; i++) begin
            if (!p0 && $urandom_range(0, 99) < 60) begin
                p0 = 1; pr0 = rand_coord(); pc0 = rand_coord();
                pw0 = $urandom_range(0, 2) == 0; pd0 = 1'($urandom_range(0, 1));
            end
            if (!p1 && $urandom_range(0, 99) < 60) begin
                p1 = 1; pr1 = rand_coord(); pc1 = rand_coord();
                pw1 = $urandom_range(0, 2) == 0; pd1 = 1'($urandom_range(0, 1));
            end
            rr = $urandom_range(0, 199) == 0;
            apply(rr, p0, pr0, pc0, pw0, pd0, p1, pr1, pc1, pw1, pd1);
            if (last_g == 0) p0 = 0;
            if (last_g == 1) p1 = 0;
        end

        idle(3);
        #4;
        chk("read queue drained", rq.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
